// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI/XIP read path.
//   AXI_RESP_OKAY / AXI_RESP_SLVERR : AXI read response encodings
//   cache_state_e                   : xip_read_cache FSM states
package qspi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_AR = 3'd2,
        ST_MISS_R  = 3'd3,
        ST_RESP    = 3'd4
    } cache_state_e;

endpackage

// File: rtl/xip_cache_mem.sv
// Line storage for xip_read_cache: LINES entries of {valid, tag, 32-bit data}.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset (clears valid bits)
//   rd_en_i/rd_idx_i : registered read port; outputs update the cycle after rd_en_i
//   rd_valid_o, rd_tag_o, rd_data_o : registered read results
//   wr_en_i, wr_idx_i, wr_tag_i, wr_data_i : line fill port, sets valid
//   clr_i            : invalidate every line; wins over a same-cycle fill
module xip_cache_mem
    import qspi_pkg::*;
#(
    parameter int LINES = 8,
    parameter int TAG_W = 27,
    parameter int IDX   = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rd_en_i,
    input  logic [IDX-1:0]   rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic             clr_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic             rd_valid_q, rd_valid_d;
    logic [TAG_W-1:0] rd_tag_q, rd_tag_d;
    logic [31:0]      rd_data_q, rd_data_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
        if (clr_i) begin
            valid_d = '0;
        end
    end

    // A flush coinciding with the lookup read must not let the stale line hit.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_tag_d   = rd_tag_q;
        rd_data_d  = rd_data_q;
        if (rd_en_i) begin
            rd_valid_d = valid_q[rd_idx_i] & ~clr_i;
            rd_tag_d   = tag_q[rd_idx_i];
            rd_data_d  = data_q[rd_idx_i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_tag_q  <= rd_tag_d;
        rd_data_q <= rd_data_d;
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/xip_read_cache.sv
// Direct-mapped read-only word cache between the CPU AXI4-Lite read port and
// the XIP engine's AXI read slave. Hits answer two cycles after AR with no
// flash access; misses do one aligned word read downstream and fill the line.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   cache_en_i               : 1 = cache on; 0 = every access misses, no fill
//   flush_i                  : one-cycle pulse, invalidate all lines
//   s_ar*/s_r*               : CPU-side AXI read address / data channels
//   m_ar*/m_r*               : XIP-engine-side AXI read address / data channels
//   hit_cnt_o, miss_cnt_o    : wrapping hit / miss counters
//   busy_o                   : FSM not idle
module xip_read_cache
    import qspi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cache_en_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [ADDR_WIDTH-1:0] m_araddr_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [31:0]           m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o,
    output logic                  busy_o
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    cache_state_e state_q, state_d;

    // Word address only; byte offset bits are dropped at capture.
    logic [ADDR_WIDTH-1:2] addr_q, addr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic                  flush_seen_q, flush_seen_d;

    logic             lookup_en;
    logic             fill_en;
    logic             hit;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;

    logic unused_byte_offset;
    assign unused_byte_offset = ^s_araddr_i[1:0];

    xip_cache_mem #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX   (IDX)
    ) u_mem (
        .clk        (clk),
        .resetn     (resetn),
        .rd_en_i    (lookup_en),
        .rd_idx_i   (s_araddr_i[IDX+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (addr_q[IDX+1:2]),
        .wr_tag_i   (addr_q[ADDR_WIDTH-1:IDX+2]),
        .wr_data_i  (m_rdata_i),
        .clr_i      (flush_i)
    );

    assign hit = rd_valid && (rd_tag == addr_q[ADDR_WIDTH-1:IDX+2]) && cache_en_i;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        flush_seen_d = flush_seen_q;
        lookup_en    = 1'b0;
        fill_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_arvalid_i) begin
                    lookup_en    = 1'b1;
                    addr_d       = s_araddr_i[ADDR_WIDTH-1:2];
                    flush_seen_d = 1'b0;
                    state_d      = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                flush_seen_d = flush_seen_q | flush_i;
                if (hit) begin
                    rdata_d   = rd_data;
                    rresp_d   = AXI_RESP_OKAY;
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = ST_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = ST_MISS_AR;
                end
            end
            ST_MISS_AR: begin
                flush_seen_d = flush_seen_q | flush_i;
                if (m_arready_i) begin
                    state_d = ST_MISS_R;
                end
            end
            ST_MISS_R: begin
                flush_seen_d = flush_seen_q | flush_i;
                if (m_rvalid_i) begin
                    rdata_d = m_rdata_i;
                    rresp_d = m_rresp_i;
                    // Any flush since lookup (including this cycle) means the
                    // fetched word may predate a program/erase; don't keep it.
                    fill_en = (m_rresp_i == AXI_RESP_OKAY) && cache_en_i &&
                              !flush_seen_q && !flush_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_rready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= AXI_RESP_OKAY;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Held low while in reset so every output reads 0 during reset.
    assign s_arready_o = resetn && (state_q == ST_IDLE);
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign s_rvalid_o  = (state_q == ST_RESP);
    assign m_araddr_o  = {addr_q, 2'b00};
    assign m_arvalid_o = (state_q == ST_MISS_AR);
    assign m_rready_o  = (state_q == ST_MISS_R);
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
